// File: rtl/fft_stage5_r2.sv
// ----------------------------------------------------------------------------
// fft_stage5_r2
//   Final radix-2 SDF stage of the 32-point FFT pipeline. Adjacent sample
//   pairs (a,b) are combined with a twiddle of W^0 through a delay-1 feedback
//   register. For each pair the stage emits a+b, followed by a-b. Every output
//   sample carries a 5-bit frame position for the downstream reorder buffer.
//
//   Optional build macro: STAGE5_SAT16_EN
//     defined   : sum/diff clamped to [-32768, 32767], sign-extended to OUT_W
//     undefined : full-precision OUT_W result, no clamping
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   valid_i      in   input sample valid
//   data_in_r/i  in   IN_W signed real/imag input
//   valid_o      out  output sample valid
//   data_out_r/i out  OUT_W signed real/imag output (holds when valid_o=0)
//   idx_o        out  5-bit output position in frame, wraps 31->0
//
// Pipeline: input reg -> FSM/feedback -> result reg -> output reg
// ----------------------------------------------------------------------------
module fft_stage5_r2 #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_i,
    input  logic signed [IN_W-1:0]  data_in_r,
    input  logic signed [IN_W-1:0]  data_in_i,
    output logic                    valid_o,
    output logic signed [OUT_W-1:0] data_out_r,
    output logic signed [OUT_W-1:0] data_out_i,
    output logic [4:0]              idx_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HALF = 2'd1;
    localparam logic [1:0] S_DIFF = 2'd2;

`ifdef STAGE5_SAT16_EN
    localparam logic signed [OUT_W-1:0] SAT_MAX = OUT_W'(32767);
    localparam logic signed [OUT_W-1:0] SAT_MIN = OUT_W'(-32768);

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [OUT_W-1:0] x);
        if (x > SAT_MAX)      return SAT_MAX;
        else if (x < SAT_MIN) return SAT_MIN;
        else                  return x;
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] sat(input logic signed [OUT_W-1:0] x);
        return x;
    endfunction
`endif

    // Input register
    logic                    v_q, v_d;
    logic signed [IN_W-1:0]  in_r_q, in_r_d;
    logic signed [IN_W-1:0]  in_i_q, in_i_d;

    // FSM and feedback register (holds a, then a-b)
    logic [1:0]              state_q, state_d;
    logic signed [OUT_W-1:0] fb_r_q, fb_r_d;
    logic signed [OUT_W-1:0] fb_i_q, fb_i_d;

    // Result register (sample produced by the FSM)
    logic                    res_v_q, res_v_d;
    logic signed [OUT_W-1:0] res_r_q, res_r_d;
    logic signed [OUT_W-1:0] res_i_q, res_i_d;

    // Output register and frame position counter
    logic                    valid_o_q, valid_o_d;
    logic signed [OUT_W-1:0] out_r_q, out_r_d;
    logic signed [OUT_W-1:0] out_i_q, out_i_d;
    logic [4:0]              idx_o_q, idx_o_d;
    logic [4:0]              cnt_q, cnt_d;

    logic signed [OUT_W-1:0] in_r_x, in_i_x;

    assign in_r_x = {{(OUT_W-IN_W){in_r_q[IN_W-1]}}, in_r_q};
    assign in_i_x = {{(OUT_W-IN_W){in_i_q[IN_W-1]}}, in_i_q};

    always_comb begin
        v_d    = valid_i;
        in_r_d = data_in_r;
        in_i_d = data_in_i;
    end

    always_comb begin
        state_d = state_q;
        fb_r_d  = fb_r_q;
        fb_i_d  = fb_i_q;
        res_v_d = 1'b0;
        res_r_d = res_r_q;
        res_i_d = res_i_q;
        case (state_q)
            S_IDLE: begin
                if (v_q) begin
                    fb_r_d  = in_r_x;
                    fb_i_d  = in_i_x;
                    state_d = S_HALF;
                end
            end
            S_HALF: begin
                if (v_q) begin
                    res_v_d = 1'b1;
                    res_r_d = sat(fb_r_q + in_r_x);
                    res_i_d = sat(fb_i_q + in_i_x);
                    fb_r_d  = fb_r_q - in_r_x;
                    fb_i_d  = fb_i_q - in_i_x;
                    state_d = S_DIFF;
                end
            end
            S_DIFF: begin
                // The pending diff drains regardless of input; a sample
                // arriving now starts the next pair.
                res_v_d = 1'b1;
                res_r_d = sat(fb_r_q);
                res_i_d = sat(fb_i_q);
                if (v_q) begin
                    fb_r_d  = in_r_x;
                    fb_i_d  = in_i_x;
                    state_d = S_HALF;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_o_d = res_v_q;
        out_r_d   = out_r_q;
        out_i_d   = out_i_q;
        idx_o_d   = idx_o_q;
        cnt_d     = cnt_q;
        if (res_v_q) begin
            out_r_d = res_r_q;
            out_i_d = res_i_q;
            idx_o_d = cnt_q;
            cnt_d   = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= 1'b0;
            in_r_q    <= '0;
            in_i_q    <= '0;
            state_q   <= S_IDLE;
            fb_r_q    <= '0;
            fb_i_q    <= '0;
            res_v_q   <= 1'b0;
            res_r_q   <= '0;
            res_i_q   <= '0;
            valid_o_q <= 1'b0;
            out_r_q   <= '0;
            out_i_q   <= '0;
            idx_o_q   <= '0;
            cnt_q     <= '0;
        end else begin
            v_q       <= v_d;
            in_r_q    <= in_r_d;
            in_i_q    <= in_i_d;
            state_q   <= state_d;
            fb_r_q    <= fb_r_d;
            fb_i_q    <= fb_i_d;
            res_v_q   <= res_v_d;
            res_r_q   <= res_r_d;
            res_i_q   <= res_i_d;
            valid_o_q <= valid_o_d;
            out_r_q   <= out_r_d;
            out_i_q   <= out_i_d;
            idx_o_q   <= idx_o_d;
            cnt_q     <= cnt_d;
        end
    end

    assign valid_o    = valid_o_q;
    assign data_out_r = out_r_q;
    assign data_out_i = out_i_q;
    assign idx_o      = idx_o_q;

endmodule

// File: tb/tb_fft_stage5_r2.sv
// ----------------------------------------------------------------------------
// tb_fft_stage5_r2
//   Self-checking bench for fft_stage5_r2. A pair-level reference model turns
//   each accepted sample into scheduled output events: when b of a pair is
//   sampled at edge e, sum appears after edge e+2 and diff after edge e+3.
//   Outputs are checked 1 time unit after every rising edge.
//   Honours STAGE5_SAT16_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_fft_stage5_r2;

    localparam int IN_W  = 17;
    localparam int OUT_W = 18;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    valid_i = 1'b0;
    logic signed [IN_W-1:0]  data_in_r = '0;
    logic signed [IN_W-1:0]  data_in_i = '0;
    logic                    valid_o;
    logic signed [OUT_W-1:0] data_out_r;
    logic signed [OUT_W-1:0] data_out_i;
    logic [4:0]              idx_o;

    always #5 clk = ~clk;

    fft_stage5_r2 #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .data_in_r  (data_in_r),
        .data_in_i  (data_in_i),
        .valid_o    (valid_o),
        .data_out_r (data_out_r),
        .data_out_i (data_out_i),
        .idx_o      (idx_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit have_a;
    int a_r, a_i;
    int edge_n = 0;
    bit sched_v [8];
    int sched_r [8];
    int sched_i [8];
    int last_r, last_i;
    int exp_idx;

    function automatic int clampv(input int x);
`ifdef STAGE5_SAT16_EN
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
`endif
        return x;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d (edge %0d)", tag, obs, expv, edge_n);
        end
    endtask

    task automatic model_reset();
        have_a  = 1'b0;
        last_r  = 0;
        last_i  = 0;
        exp_idx = 0;
        for (int k = 0; k < 8; k++) sched_v[k] = 1'b0;
    endtask

    task automatic schedule(input int at, input int r, input int i);
        sched_v[at % 8] = 1'b1;
        sched_r[at % 8] = clampv(r);
        sched_i[at % 8] = clampv(i);
    endtask

    // One clock cycle: drive on the falling edge, check after the rising edge.
    task automatic step(input bit rn, input bit v, input int r, input int i);
        int  slot;
        bit  ev;
        @(negedge clk);
        rst_n     = rn;
        valid_i   = v;
        data_in_r = IN_W'(r);
        data_in_i = IN_W'(i);
        if (!rn) model_reset();
        @(posedge clk);
        edge_n++;
        if (rn && v) begin
            if (have_a) begin
                schedule(edge_n + 2, a_r + r, a_i + i);
                schedule(edge_n + 3, a_r - r, a_i - i);
                have_a = 1'b0;
            end else begin
                have_a = 1'b1;
                a_r    = r;
                a_i    = i;
            end
        end
        #1;
        slot = edge_n % 8;
        ev   = sched_v[slot];
        sched_v[slot] = 1'b0;
        if (ev) begin
            last_r = sched_r[slot];
            last_i = sched_i[slot];
        end
        chk("valid_o", {31'd0, valid_o}, {31'd0, ev});
        chk("data_out_r", data_out_r, last_r);
        chk("data_out_i", data_out_i, last_i);
        if (ev) begin
            chk("idx_o", {27'd0, idx_o}, exp_idx);
            exp_idx = (exp_idx + 1) % 32;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 131071)) - 65536,
                 int'($urandom_range(0, 131071)) - 65536);
    endtask

    initial begin
        model_reset();

        // 1. Reset with random inputs: outputs stay at zero
        do_reset(6);
        idle(2);

        // 2. Single pair
        step(1'b1, 1'b1, 100, -50);
        step(1'b1, 1'b1, 30, 20);
        idle(5);

        // 3. 32 back-to-back samples x[n]=(n,-n), then one more pair
        do_reset(2);
        for (int n = 0; n < 32; n++) step(1'b1, 1'b1, n, -n);
        step(1'b1, 1'b1, 7, 7);
        step(1'b1, 1'b1, 3, 1);
        idle(5);

        // 4. Bubble between a and b
        step(1'b1, 1'b1, 5, 5);
        idle(3);
        step(1'b1, 1'b1, 1, 2);
        idle(4);

        // 5. Range extremes
        step(1'b1, 1'b1, 65535, -65536);
        step(1'b1, 1'b1, 65535, -65536);
        step(1'b1, 1'b1, -65536, 65535);
        step(1'b1, 1'b1, 65535, -65536);
        idle(5);

        // 6. Reset between a and b discards the pending a
        step(1'b1, 1'b1, 40, 40);
        do_reset(1);
        step(1'b1, 1'b1, 1, 1);
        step(1'b1, 1'b1, 2, 2);
        idle(5);

        // Randomized traffic with bubbles and an occasional reset
        for (int k = 0; k < 400; k++) begin
            if (k == 213) do_reset(2);
            step(1'b1, $urandom_range(0, 9) < 7,
                 int'($urandom_range(0, 131071)) - 65536,
                 int'($urandom_range(0, 131071)) - 65536);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
